draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arb_pkg.sv | 53 +++++
 rtl/draw_arb_picker.sv | 64 ++++++
 rtl/draw_arbiter.sv | 135 +++++++++++++
 tb/tb_draw_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the draw arbiter.
// Optional feature macro: DRAW_ARB_ROUND_ROBIN_EN (round-robin winner selection).
package draw_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_BG    = 0;
    localparam int REQ_CHAR  = 1;
    localparam int REQ_SCENE = 2;

    localparam int DEF_XW = 8;
    localparam int DEF_YW = 7;
    localparam int DEF_CW = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_t;

    // One-hot of the first pending requester, scanning indices in the order a, b, c.
    function automatic logic [NUM_REQ-1:0] pick_first(
        input logic [NUM_REQ-1:0] pending,
        input int                 a,
        input int                 b,
        input int                 c
    );
        logic [NUM_REQ-1:0] res;
        res = 3'b000;
        if (pending[a]) begin
            res[a] = 1'b1;
        end else if (pending[b]) begin
            res[b] = 1'b1;
        end else if (pending[c]) begin
            res[c] = 1'b1;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Index of a one-hot vector; zero vector maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/draw_arb_picker.sv
// Winner selection and grant register for the draw arbiter.
// DRAW_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority 0 > 1 > 2.
module draw_arb_picker
    import draw_arb_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] pending,
    input  logic               load,
    input  logic               clear,
    output logic [NUM_REQ-1:0] winner,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] winner_s;
    logic [NUM_REQ-1:0] grant_r;

`ifdef DRAW_ARB_ROUND_ROBIN_EN
    logic [1:0] last_r;

    // Scan starting just after the last granted index, wrapping 2 -> 0.
    always_comb begin
        winner_s = 3'b000;
        case (last_r)
            2'd0:    winner_s = pick_first(pending, 1, 2, 0);
            2'd1:    winner_s = pick_first(pending, 2, 0, 1);
            default: winner_s = pick_first(pending, 0, 1, 2);
        endcase
    end

    // Remember the last granted index; reset value 2 makes index 0 win first.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_r <= 2'd2;
        end else if (load && (winner_s != 3'b000)) begin
            last_r <= onehot_to_idx(winner_s);
        end else begin
            last_r <= last_r;
        end
    end
`else
    // Fixed priority: BG restore beats character beats scenery.
    always_comb begin
        winner_s = pick_first(pending, REQ_BG, REQ_CHAR, REQ_SCENE);
    end
`endif

    // Grant is loaded when leaving IDLE and dropped when a draw finishes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            grant_r <= 3'b000;
        end else if (load) begin
            grant_r <= winner_s;
        end else if (clear) begin
            grant_r <= 3'b000;
        end else begin
            grant_r <= grant_r;
        end
    end

    assign winner = winner_s;
    assign grant  = grant_r;

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates three draw engines onto one framebuffer write port.
// Optional feature macro: DRAW_ARB_ROUND_ROBIN_EN (round-robin winner selection).
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    parameter int CW = DEF_CW
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    done,
    input  logic [NUM_REQ*XW-1:0] px_x,
    input  logic [NUM_REQ*YW-1:0] px_y,
    input  logic [NUM_REQ*CW-1:0] px_colour,
    input  logic [NUM_REQ-1:0]    px_plot,
    output logic [NUM_REQ-1:0]    start,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic [XW-1:0]         vga_x,
    output logic [YW-1:0]         vga_y,
    output logic [CW-1:0]         vga_colour,
    output logic                  vga_plot,
    output logic                  busy
);

    arb_state_t         state_r;
    arb_state_t         state_s;
    logic [NUM_REQ-1:0] pending_r;
    logic [NUM_REQ-1:0] pending_s;
    logic [NUM_REQ-1:0] start_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               busy_r;
    logic [NUM_REQ-1:0] winner_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               owner_done_s;

    draw_arb_picker u_picker (
        .clock   (clock),
        .resetn  (resetn),
        .pending (pending_r),
        .load    (state_r == ST_IDLE),
        .clear   (state_r == ST_FINISH),
        .winner  (winner_s),
        .grant   (grant_s)
    );

    assign owner_done_s = |(done & grant_s);

    // Next state and pending update; a new request beats the FINISH clear.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r | req;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 3'b000) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_RUN;
            ST_RUN: begin
                if (owner_done_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_s   = ST_IDLE;
                pending_s = (pending_r & ~grant_s) | req;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, pending and the registered start/ack/busy pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            pending_r <= 3'b000;
            start_r   <= 3'b000;
            ack_r     <= 3'b000;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            start_r   <= ((state_r == ST_IDLE) && (pending_r != 3'b000)) ? winner_s : 3'b000;
            ack_r     <= ((state_r == ST_RUN) && owner_done_s) ? grant_s : 3'b000;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    // Framebuffer mux: only the owner's buses and strobe reach the port.
    always_comb begin
        vga_x      = {XW{1'b0}};
        vga_y      = {YW{1'b0}};
        vga_colour = {CW{1'b0}};
        case (grant_s)
            3'b001: begin
                vga_x      = px_x[0*XW +: XW];
                vga_y      = px_y[0*YW +: YW];
                vga_colour = px_colour[0*CW +: CW];
            end
            3'b010: begin
                vga_x      = px_x[1*XW +: XW];
                vga_y      = px_y[1*YW +: YW];
                vga_colour = px_colour[1*CW +: CW];
            end
            3'b100: begin
                vga_x      = px_x[2*XW +: XW];
                vga_y      = px_y[2*YW +: YW];
                vga_colour = px_colour[2*CW +: CW];
            end
            default: begin
                vga_x      = {XW{1'b0}};
                vga_y      = {YW{1'b0}};
                vga_colour = {CW{1'b0}};
            end
        endcase
        if (state_r == ST_RUN) begin
            vga_plot = |(px_plot & grant_s);
        end else begin
            vga_plot = 1'b0;
        end
    end

    assign start = start_r;
    assign ack   = ack_r;
    assign grant = grant_s;
    assign busy  = busy_r;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected start/ack events are queued by
// the stimulus and checked by a negedge monitor; other outputs are checked directly.
module tb_draw_arbiter;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int K_START = 0;
    localparam int K_ACK   = 1;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [2:0]      req = 3'b000;
    logic [2:0]      done = 3'b000;
    logic [3*XW-1:0] px_x = '0;
    logic [3*YW-1:0] px_y = '0;
    logic [3*CW-1:0] px_colour = '0;
    logic [2:0]      px_plot = 3'b000;
    logic [2:0]      start;
    logic [2:0]      ack;
    logic [2:0]      grant;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot;
    logic            busy;

    typedef struct {
        int         kind;
        logic [2:0] val;
        int         cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    draw_arbiter #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .done       (done),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_colour  (px_colour),
        .px_plot    (px_plot),
        .start      (start),
        .ack        (ack),
        .grant      (grant),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_req(input logic [2:0] v);
        req = v;
        tick();
        req = 3'b000;
    endtask

    task automatic pulse_done(input logic [2:0] v);
        done = v;
        tick();
        done = 3'b000;
    endtask

    task automatic expect_ev(input int kind, input logic [2:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon_check(input int kind, input logic [2:0] val);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got kind=%0d val=%b at cyc %0d, expected no event", kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                n_err++;
                $display("FAIL sb_event: got kind=%0d val=%b cyc=%0d, expected kind=%0d val=%b cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every start/ack pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (start != 3'b000) mon_check(K_START, start);
            if (ack != 3'b000) mon_check(K_ACK, ack);
        end
    end

    initial begin
        int c;
        logic [2:0] first_g;
        logic [2:0] second_g;

        // Reset state
        repeat (3) tick();
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {29'd0, start}, 32'd0);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_vga_plot", {31'd0, vga_plot}, 32'd0);
        resetn = 1'b1;
        tick();

        // Single BG request: start two cycles after req, ack one cycle after done
        c = cyc;
        expect_ev(K_START, 3'b001, c + 2);
        pulse_req(3'b001);
        wait_to(c + 3);
        chk("t1_grant_run", {29'd0, grant}, 32'd1);
        chk("t1_busy_run", {31'd0, busy}, 32'd1);
        wait_to(c + 10);
        expect_ev(K_ACK, 3'b001, c + 11);
        pulse_done(3'b001);
        wait_to(c + 12);
        chk("t1_grant_after", {29'd0, grant}, 32'd0);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Simultaneous BG + character requests
`ifdef DRAW_ARB_ROUND_ROBIN_EN
        first_g  = 3'b010;
        second_g = 3'b001;
`else
        first_g  = 3'b001;
        second_g = 3'b010;
`endif
        c = cyc;
        expect_ev(K_START, first_g, c + 2);
        pulse_req(3'b011);
        wait_to(c + 5);
        expect_ev(K_ACK, first_g, c + 6);
        expect_ev(K_START, second_g, c + 8);
        pulse_done(first_g);
        wait_to(c + 9);
        chk("t2_second_grant", {29'd0, grant}, {29'd0, second_g});
        wait_to(c + 11);
        expect_ev(K_ACK, second_g, c + 12);
        pulse_done(second_g);
        wait_to(c + 14);

        // Framebuffer mux isolation during a character draw
        px_x      = {8'd9, 8'd40, 8'd5};
        px_y      = {7'd2, 7'd30, 7'd1};
        px_colour = {3'd6, 3'd3, 3'd1};
        px_plot   = 3'b111;
        #1;
        chk("t3_idle_vga_x", {24'd0, vga_x}, 32'd0);
        chk("t3_idle_vga_plot", {31'd0, vga_plot}, 32'd0);
        px_plot = 3'b000;
        c = cyc;
        expect_ev(K_START, 3'b010, c + 2);
        pulse_req(3'b010);
        wait_to(c + 4);
        px_plot = 3'b101;
        #1;
        chk("t3_foreign_plot", {31'd0, vga_plot}, 32'd0);
        px_plot = 3'b010;
        #1;
        chk("t3_own_plot", {31'd0, vga_plot}, 32'd1);
        chk("t3_vga_x", {24'd0, vga_x}, 32'd40);
        chk("t3_vga_y", {25'd0, vga_y}, 32'd30);
        chk("t3_vga_colour", {29'd0, vga_colour}, 32'd3);
        px_plot = 3'b000;
        pulse_done(3'b101);
        wait_to(c + 7);
        chk("t3_busy_foreign_done", {31'd0, busy}, 32'd1);
        chk("t3_grant_foreign_done", {29'd0, grant}, 32'd2);
        expect_ev(K_ACK, 3'b010, c + 8);
        pulse_done(3'b010);
        wait_to(c + 10);

        // Request arriving in the FINISH cycle is kept and re-served
        c = cyc;
        expect_ev(K_START, 3'b010, c + 2);
        pulse_req(3'b010);
        wait_to(c + 5);
        expect_ev(K_ACK, 3'b010, c + 6);
        pulse_done(3'b010);
        expect_ev(K_START, 3'b010, c + 8);
        pulse_req(3'b010);
        chk("t4_grant_idle", {29'd0, grant}, 32'd0);
        wait_to(c + 10);
        expect_ev(K_ACK, 3'b010, c + 11);
        pulse_done(3'b010);
        wait_to(c + 13);

        // done from a non-granted engine is ignored
        c = cyc;
        expect_ev(K_START, 3'b001, c + 2);
        pulse_req(3'b001);
        wait_to(c + 4);
        pulse_done(3'b100);
        wait_to(c + 6);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_grant", {29'd0, grant}, 32'd1);
        wait_to(c + 7);
        expect_ev(K_ACK, 3'b001, c + 8);
        pulse_done(3'b001);
        wait_to(c + 10);

        // Reset mid-draw aborts; later done gives no ack, no re-issue
        c = cyc;
        expect_ev(K_START, 3'b010, c + 2);
        pulse_req(3'b010);
        wait_to(c + 4);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        px_plot = 3'b010;
        #1;
        chk("t6_grant", {29'd0, grant}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_vga_plot", {31'd0, vga_plot}, 32'd0);
        px_plot = 3'b000;
        pulse_done(3'b010);
        wait_to(c + 15);
        chk("t6_busy_late", {31'd0, busy}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
